// File: rtl/conv1d_mac_engine.sv
// conv1d_mac_engine: ring-buffered int8 1-D convolution MAC engine
// behind a custom-instruction command port.
module conv1d_mac_engine #(
  parameter int BYTE_SIZE          = 8,
  parameter int INT32_SIZE         = 32,
  parameter int KERNEL_LENGTH      = 8,
  parameter int MAX_INPUT_CHANNELS = 128,
  parameter int LANES              = 8,
  parameter int BUFFERS_SIZE       =
    KERNEL_LENGTH * MAX_INPUT_CHANNELS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  input  logic [6:0]            cmd,
  input  logic [INT32_SIZE-1:0] inp0,
  input  logic [INT32_SIZE-1:0] inp1,
  output logic [INT32_SIZE-1:0] ret,
  output logic                  output_buffer_valid
);

  localparam int AW = $clog2(BUFFERS_SIZE);
  localparam int TW = AW + 1;
  localparam int DW = $clog2(MAX_INPUT_CHANNELS + 1);
  localparam int SW =
    (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1;
  localparam int XW = INT32_SIZE - BYTE_SIZE;

  localparam logic [6:0] CMD_CLEAR = 7'd0;
  localparam logic [6:0] CMD_WIN   = 7'd1;
  localparam logic [6:0] CMD_WFLT  = 7'd2;
  localparam logic [6:0] CMD_OFS   = 7'd3;
  localparam logic [6:0] CMD_DEPTH = 7'd5;
  localparam logic [6:0] CMD_START = 7'd6;
  localparam logic [6:0] CMD_ACC   = 7'd7;
  localparam logic [6:0] CMD_SX    = 7'd8;
  localparam logic [6:0] CMD_STAT  = 7'd9;
  localparam logic [6:0] CMD_RIN   = 7'd10;
  localparam logic [6:0] CMD_RFLT  = 7'd11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC
  } state_t;

  function automatic logic [INT32_SIZE-1:0] sext(
    input logic [BYTE_SIZE-1:0] b
  );
    return {{XW{b[BYTE_SIZE-1]}}, b};
  endfunction

  logic [BYTE_SIZE-1:0] input_buffer  [BUFFERS_SIZE];
  logic [BYTE_SIZE-1:0] filter_buffer [BUFFERS_SIZE];

  state_t                state;
  logic [INT32_SIZE-1:0] acc;
  logic [INT32_SIZE-1:0] input_offset;
  logic [INT32_SIZE-1:0] input_depth;
  logic [INT32_SIZE-1:0] start_x;
  logic                  done;
  logic                  busy;
  logic                  err;
  logic [TW-1:0]         kaddr;
  logic [TW-1:0]         iaddr;
  logic [TW-1:0]         total;
  logic [TW-1:0]         beats;
  logic [BYTE_SIZE-1:0]  f_q [LANES];
  logic [BYTE_SIZE-1:0]  x_q [LANES];

  logic                  in_range;
  logic [AW-1:0]         addr;
  logic [TW-1:0]         total_n;
  logic [TW-1:0]         iaddr_n;
  logic [TW-1:0]         beats_n;
  logic                  start_ok;
  logic                  locked;
  logic [TW-1:0]         lane_i [LANES];
  logic [TW-1:0]         iaddr_step;
  logic [INT32_SIZE-1:0] mac_sum;

  assign in_range =
    inp0 < INT32_SIZE'(BUFFERS_SIZE);
  assign addr = inp0[AW-1:0];

  assign total_n =
    TW'(KERNEL_LENGTH) * TW'(input_depth[DW-1:0]);
  assign iaddr_n =
    TW'(start_x[SW-1:0]) * TW'(input_depth[DW-1:0]);
  assign beats_n = total_n / TW'(LANES);

  assign start_ok =
    (input_depth <= INT32_SIZE'(MAX_INPUT_CHANNELS)) &&
    (start_x < INT32_SIZE'(KERNEL_LENGTH));

  assign locked = busy &&
    !(cmd == CMD_CLEAR ||
      cmd == CMD_ACC ||
      cmd == CMD_STAT);

  // Ring-wrapped input addresses for the lanes of one beat
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_i[i] = iaddr + TW'(i);
      if (lane_i[i] >= total)
        lane_i[i] = lane_i[i] - total;
    end
  end

  // Next beat's window start, wrapped around the window
  always_comb begin
    iaddr_step = iaddr + TW'(LANES);
    if (iaddr_step >= total)
      iaddr_step = iaddr_step - total;
  end

  // Sum of lane products with the input zero-point applied
  always_comb begin
    mac_sum = '0;
    for (int i = 0; i < LANES; i++)
      mac_sum = mac_sum + sext(f_q[i]) *
        (sext(x_q[i]) + input_offset);
  end

  // Buffer writes; contents are not reset
  always_ff @(posedge clk) begin
    if (cmd_valid && !busy && in_range) begin
      if (cmd == CMD_WIN)
        input_buffer[addr] <= inp1[BYTE_SIZE-1:0];
      if (cmd == CMD_WFLT)
        filter_buffer[addr] <= inp1[BYTE_SIZE-1:0];
    end
  end

  // MAC sequencer and command decode; commands override the run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      ret                 <= '0;
      output_buffer_valid <= 1'b1;
      acc                 <= '0;
      input_offset        <= '0;
      input_depth         <= '0;
      start_x             <= '0;
      done                <= 1'b1;
      busy                <= 1'b0;
      err                 <= 1'b0;
      kaddr               <= '0;
      iaddr               <= '0;
      total               <= '0;
      beats               <= '0;
      for (int i = 0; i < LANES; i++) begin
        f_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: ;
        LOAD: begin
          for (int i = 0; i < LANES; i++) begin
            f_q[i] <=
              filter_buffer[AW'(kaddr + TW'(i))];
            x_q[i] <= input_buffer[AW'(lane_i[i])];
          end
          state <= MAC;
        end
        MAC: begin
          acc   <= acc + mac_sum;
          kaddr <= kaddr + TW'(LANES);
          iaddr <= iaddr_step;
          beats <= beats - 1'b1;
          if (beats == TW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase

      if (cmd_valid) begin
        output_buffer_valid <= 1'b1;
        ret                 <= '0;
        if (locked) begin
          err <= 1'b1;
        end else begin
          case (cmd)
            CMD_CLEAR: begin
              acc   <= '0;
              err   <= 1'b0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
            CMD_WIN, CMD_WFLT: begin
              if (!in_range) err <= 1'b1;
            end
            CMD_OFS:   input_offset <= inp1;
            CMD_DEPTH: input_depth  <= inp1;
            CMD_SX:    start_x      <= inp1;
            CMD_ACC:   ret <= acc;
            CMD_STAT:
              ret <= {29'b0, err, busy, done};
            CMD_RIN: begin
              if (in_range)
                ret <= sext(input_buffer[addr]);
              else
                err <= 1'b1;
            end
            CMD_RFLT: begin
              if (in_range)
                ret <= sext(filter_buffer[addr]);
              else
                err <= 1'b1;
            end
            CMD_START: begin
              if (!start_ok) begin
                err <= 1'b1;
              end else begin
                acc <= '0;
                if (beats_n == '0) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                end else begin
                  done  <= 1'b0;
                  busy  <= 1'b1;
                  state <= LOAD;
                  kaddr <= '0;
                  iaddr <= iaddr_n;
                  total <= total_n;
                  beats <= beats_n;
                end
              end
            end
            default: err <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_conv1d_mac_engine.sv
// tb_conv1d_mac_engine: directed vector table plus
// hand-written multi-cycle run sequences.
module tb_conv1d_mac_engine;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [6:0]  cmd;
  logic [31:0] inp0;
  logic [31:0] inp1;
  logic [31:0] ret;
  logic        output_buffer_valid;

  conv1d_mac_engine dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cmd_valid           (cmd_valid),
    .cmd                 (cmd),
    .inp0                (inp0),
    .inp1                (inp1),
    .ret                 (ret),
    .output_buffer_valid (output_buffer_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  c;
    logic [31:0] a;
    logic [31:0] v;
    logic [31:0] e;
    string       nm;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h",
                  nm, act, exp);
  endtask

  task automatic do_cmd(input logic [6:0] c,
                        input logic [31:0] a,
                        input logic [31:0] v,
                        output logic [31:0] r);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = c;
    inp0 = a;
    inp1 = v;
    @(posedge clk);
    #1;
    r = ret;
    cmd_valid = 1'b0;
  endtask

  function automatic void add(input logic [6:0] c,
                              input logic [31:0] a,
                              input logic [31:0] v,
                              input logic [31:0] e,
                              input string nm);
    vec_t t;
    t.c = c; t.a = a; t.v = v; t.e = e; t.nm = nm;
    vecs.push_back(t);
  endfunction

  // start, poll status counting busy cycles, then read acc
  task automatic run_check(input string nm,
                           input int exp_busy,
                           input logic [31:0] exp_acc,
                           input logic [31:0] exp_stat);
    logic [31:0] r;
    int n;
    bit fin;
    do_cmd(7'd6, 0, 0, r);
    n = 0;
    fin = 0;
    for (int k = 0; k < 1000; k++) begin
      do_cmd(7'd9, 0, 0, r);
      if (r[1]) n++;
      else begin
        fin = 1;
        break;
      end
    end
    check({nm, " finished"}, 32'(fin), 32'd1);
    check({nm, " busy_cycles"}, n, exp_busy);
    check({nm, " status"}, r, exp_stat);
    do_cmd(7'd7, 0, 0, r);
    check({nm, " acc"}, r, exp_acc);
  endtask

  initial begin
    logic [31:0] r;
    int n;
    bit fin;
    n_pass = 0;
    n_total = 0;
    cmd_valid = 1'b0;
    cmd = '0;
    inp0 = '0;
    inp1 = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ret", ret, 32'd0);
    check("reset obv", 32'(output_buffer_valid), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    do_cmd(7'd9, 0, 0, r);
    check("reset status", r, 32'd1);
    check("obv after cmd", 32'(output_buffer_valid), 32'd1);
    do_cmd(7'd7, 0, 0, r);
    check("reset acc", r, 32'd0);

    for (int i = 0; i < 8; i++) begin
      add(7'd1, i, i, 0, "wr input");
      add(7'd2, i, 1, 0, "wr filter");
    end
    add(7'd1, 9, 32'h80, 0, "wr input9");
    add(7'd10, 9, 0, 32'hFFFF_FF80, "rd sext");
    add(7'd10, 3, 0, 3, "rd input3");
    add(7'd11, 5, 0, 1, "rd filter5");
    add(7'd3, 0, 0, 0, "set offset");
    add(7'd5, 0, 1, 0, "set depth");
    add(7'd8, 0, 0, 0, "set sx");
    add(7'd9, 0, 0, 1, "status clean");
    add(7'd10, 1024, 0, 0, "rd oob");
    add(7'd9, 0, 0, 5, "status oob err");
    add(7'd0, 0, 0, 0, "clear");
    add(7'd9, 0, 0, 1, "status cleared");
    add(7'd1, 1024, 9, 0, "wr oob");
    add(7'd9, 0, 0, 5, "status wr oob");
    add(7'd0, 0, 0, 0, "clear2");
    add(7'd4, 0, 0, 0, "unknown cmd");
    add(7'd9, 0, 0, 5, "status unknown");
    add(7'd0, 0, 0, 0, "clear3");
    add(7'd8, 0, 8, 0, "sx=8");
    add(7'd6, 0, 0, 0, "start sx8");
    add(7'd9, 0, 0, 5, "status sx8");
    add(7'd0, 0, 0, 0, "clear4");
    add(7'd8, 0, 0, 0, "sx=0");
    add(7'd5, 0, 200, 0, "depth=200");
    add(7'd6, 0, 0, 0, "start d200");
    add(7'd9, 0, 0, 5, "status d200");
    add(7'd0, 0, 0, 0, "clear5");
    add(7'd5, 0, 0, 0, "depth=0");
    add(7'd6, 0, 0, 0, "start d0");
    add(7'd9, 0, 0, 1, "status d0");
    add(7'd7, 0, 0, 0, "acc d0");
    add(7'd5, 0, 1, 0, "depth=1");

    foreach (vecs[i]) begin
      do_cmd(vecs[i].c, vecs[i].a, vecs[i].v, r);
      check(vecs[i].nm, r, vecs[i].e);
    end

    run_check("run basic", 2, 32'd28, 32'd1);

    do_cmd(7'd8, 0, 8, r);
    do_cmd(7'd6, 0, 0, r);
    do_cmd(7'd7, 0, 0, r);
    check("reject keeps acc", r, 32'd28);
    do_cmd(7'd0, 0, 0, r);
    do_cmd(7'd8, 0, 0, r);

    do_cmd(7'd6, 0, 0, r);
    do_cmd(7'd9, 0, 0, r);
    check("sim busy", r, 32'd2);
    do_cmd(7'd7, 0, 0, r);
    check("sim acc pre", r, 32'd0);
    do_cmd(7'd9, 0, 0, r);
    check("sim done", r, 32'd1);
    do_cmd(7'd7, 0, 0, r);
    check("sim acc post", r, 32'd28);

    do_cmd(7'd6, 0, 0, r);
    do_cmd(7'd9, 0, 0, r);
    do_cmd(7'd9, 0, 0, r);
    check("sim stat last", r, 32'd2);
    do_cmd(7'd9, 0, 0, r);
    check("sim stat after", r, 32'd1);

    do_cmd(7'd3, 0, 128, r);
    run_check("run ofs128", 2, 32'd1052, 32'd1);
    do_cmd(7'd3, 0, 32'hFFFF_FFFD, r);
    run_check("run ofs-3", 2, 32'd4, 32'd1);

    do_cmd(7'd3, 0, 0, r);
    do_cmd(7'd8, 0, 2, r);
    for (int i = 1; i < 7; i++)
      do_cmd(7'd2, i, 0, r);
    do_cmd(7'd2, 7, 5, r);
    run_check("run wrap", 2, 32'd7, 32'd1);

    for (int i = 0; i < 1024; i++) begin
      do_cmd(7'd1, i, 127, r);
      do_cmd(7'd2, i, 127, r);
    end
    do_cmd(7'd8, 0, 0, r);
    do_cmd(7'd5, 0, 128, r);
    do_cmd(7'd6, 0, 0, r);
    do_cmd(7'd1, 0, 5, r);
    check("lockout ret", r, 32'd0);
    do_cmd(7'd9, 0, 0, r);
    check("lockout status", r, 32'd6);
    n = 2;
    fin = 0;
    for (int k = 0; k < 1000; k++) begin
      do_cmd(7'd9, 0, 0, r);
      if (r[1]) n++;
      else begin
        fin = 1;
        break;
      end
    end
    check("big finished", 32'(fin), 32'd1);
    check("big busy_cycles", n, 32'd256);
    check("big status", r, 32'd5);
    do_cmd(7'd7, 0, 0, r);
    check("big acc", r, 32'd16516096);
    do_cmd(7'd10, 0, 0, r);
    check("lockout buf", r, 32'd127);

    do_cmd(7'd0, 0, 0, r);
    do_cmd(7'd5, 0, 16, r);
    do_cmd(7'd6, 0, 0, r);
    repeat (4) do_cmd(7'd9, 0, 0, r);
    check("midrun busy", r, 32'd2);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrun reset ret", ret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_cmd(7'd9, 0, 0, r);
    check("midrun status", r, 32'd1);
    do_cmd(7'd7, 0, 0, r);
    check("midrun acc", r, 32'd0);
    repeat (40) do_cmd(7'd9, 0, 0, r);
    check("midrun stays idle", r, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv1d_mac_engine.md
Name: conv1d_mac_engine

Overview:
- Parametrised successor to the single-shot conv1d test CFU.
- Holds one kernel window of int8 inputs as a ring buffer, plus the matching int8 filter weights.
- A start command runs an autonomous multi-beat MAC over KERNEL_LENGTH*input_depth elements, LANES elements per beat, with ring wrap of the input window.
- Sits behind the CPU custom-instruction port; firmware polls status, then reads the 32-bit accumulator.

Parameters:
- BYTE_SIZE, 8, buffer element width (signed)
- INT32_SIZE, 32, data/accumulator width
- KERNEL_LENGTH, 8, taps per channel
- MAX_INPUT_CHANNELS, 128, maximum input_depth
- LANES, 8, products summed per MAC beat; must divide KERNEL_LENGTH
- BUFFERS_SIZE, KERNEL_LENGTH*MAX_INPUT_CHANNELS, entries per buffer (derived)

Ports:
- clk, input, 1, single clock; all state on rising edge
- reset_n, input, 1, asynchronous active-low reset
- cmd_valid, input, 1, command strobe; cmd/inp0/inp1 sampled only when high
- cmd, input, 7, command code
- inp0, input, INT32_SIZE, address / selector
- inp1, input, INT32_SIZE, value
- ret, output, INT32_SIZE, response register
- output_buffer_valid, output, 1, high when ret holds the response to the last accepted command

Behaviour:
- Reset (reset_n low, async):
  - ret=0, output_buffer_valid=1, state=IDLE, acc=0
  - input_offset=0, input_depth=0, start_x=0
  - done=1, busy=0, err=0
  - Buffer contents are undefined.
- Command response timing:
  - Every accepted command drives ret and output_buffer_valid=1 on the next edge.
  - Write and parameter commands return ret=0.
  - Unknown codes return ret=0 and set err.
- Commands:
  - 0 soft clear: acc=0, err=0, done=1; aborts any run.
  - 1 write input_buffer[inp0]=inp1[7:0].
  - 2 write filter_buffer[inp0]=inp1[7:0].
  - 3 input_offset=inp1.
  - 5 input_depth=inp1.
  - 6 start.
  - 7 ret=acc.
  - 8 start_x=inp1.
  - 9 ret={29'b0,err,busy,done}.
  - 10 ret=sign-extended input_buffer[inp0].
  - 11 ret=sign-extended filter_buffer[inp0].
- Range checks:
  - Commands 1/2/10/11 with inp0>=BUFFERS_SIZE: write dropped (reads return 0), err set.
  - input_depth>MAX_INPUT_CHANNELS or start_x>=KERNEL_LENGTH at start: start rejected, err set, acc unchanged, state stays IDLE.
- Busy lockout: while busy, only 0, 7 and 9 are honoured. Any other command is dropped, returns ret=0, and sets err.
- FSM IDLE -> LOAD -> MAC -> (LOAD | IDLE):
  - start (IDLE): acc=0, done=0, busy=1, kaddr=0, iaddr=start_x*input_depth, N=KERNEL_LENGTH*input_depth/LANES.
  - start with N=0: done=1 and busy=0 on the next edge; acc=0.
  - LOAD: registers LANES filter bytes at kaddr+i and LANES input bytes at (iaddr+i) mod (KERNEL_LENGTH*input_depth).
  - MAC: acc += sum over i of filter_i*(input_i+input_offset); kaddr+=LANES; iaddr+=LANES, wrapping by subtracting KERNEL_LENGTH*input_depth.
  - After the N-th MAC: state=IDLE, busy=0, done=1.
  - busy is high for exactly 2N cycles, starting the edge after start is accepted.
- Arithmetic:
  - Operands are sign-extended to INT32_SIZE.
  - Products and the sum are taken modulo 2^INT32_SIZE (wrap, no saturation).
- Simultaneous events:
  - Command 7 in the same cycle as the final MAC returns the pre-update acc.
  - Command 9 in that cycle returns busy=1, done=0.
- reset_n asserted mid-run: immediate return to reset values; no partial acc survives.

Test Plan:
- depth=1, filter all 1, input=0..7, offset=0, start, poll 9 until done -> busy high exactly 2 cycles; cmd 7 ret=28.
- Same data, offset=128 -> ret=28+8*128=1052. Then offset=-3 -> ret=4.
- depth=1, start_x=2, filter=[1,0,0,0,0,0,0,5], input=0..7 -> window wraps, acc=input[2]+5*input[1]=2+5=7.
- depth=128, all buffers 127, offset=0 -> busy 256 cycles; ret=1024*16129=16516096.
- During busy, issue cmd 1 -> buffer unchanged, ret=0; status ret=0b110 (err, busy, not done); after completion, status=0b101.
- Reset edge cases:
  - Assert reset_n low at cycle 5 of a depth-16 run -> ret=0, status=0b001, acc=0.
  - Separately, depth=0 start -> status=0b001 next cycle, acc=0.
  - Separately, start_x=8 start -> err set, state IDLE.
